sensor_frontend: RTL and testbench

Sensor acquisition front-end that produces the `Moisture_sensor` and `Water_sensor` buses consumed by the irrigation controller (`water`). It drives the moisture ADC over a 3-wire serial read-only interface and averages 2^AVG_LOG2 conversions into one 8-bit reading. It also synchronises and debounces the 2-bit float-switch tank level. It is the producing end of the sensor interface the controller reads.

---
 rtl/sensor_pkg.sv | 17 +
 rtl/level_debounce.sv | 68 ++++++
 rtl/sensor_frontend.sv | 160 ++++++++++++++++
 tb/tb_sensor_frontend.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// sensor_pkg
// Shared definitions for the sensor acquisition front-end: the ADC
// sequencer state encoding and the widths of the two sensor buses handed
// to the irrigation controller.
package sensor_pkg;

  localparam int ADC_BITS   = 8;
  localparam int WATER_BITS = 2;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ACC,
    PUBLISH
  } adc_state_t;

endpackage

// File: rtl/level_debounce.sv
// level_debounce
// Brings an asynchronous multi-bit level into the clock domain and only
// accepts a new value once it has been stable for DEBOUNCE consecutive
// cycles after synchronisation. Every code of the bus is a legal level.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   raw    unsynchronised input level
//   level  debounced, registered level
module level_debounce
  import sensor_pkg::*;
#(
  parameter int WIDTH    = WATER_BITS,
  parameter int DEBOUNCE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_prev;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // The counter holds how many consecutive cycles the synchronised value
  // has differed from the published level without changing. A value that
  // moves, or falls back to the published level, starts the count over.
  always_comb begin
    cnt_nxt = stable_cnt;
    if (sync_q == level) begin
      cnt_nxt = '0;
    end else if (sync_q != sync_prev) begin
      cnt_nxt = CNT_W'(1);
    end else begin
      cnt_nxt = stable_cnt + 1'b1;
    end
  end

  // sync_prev is one cycle behind sync_q so a change of the candidate
  // value can be seen in the same cycle it arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta  <= '0;
      sync_q     <= '0;
      sync_prev  <= '0;
      stable_cnt <= '0;
      level      <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
      if (cnt_nxt == CNT_DONE) begin
        level      <= sync_q;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= cnt_nxt;
      end
    end
  end

endmodule

// File: rtl/sensor_frontend.sv
// sensor_frontend
// Producing end of the sensor interface read by the irrigation controller.
// Reads the moisture ADC over a 3-wire read-only serial link, averages
// 2^AVG_LOG2 conversions into one 8-bit reading, and debounces the float
// switch tank level.
//
// Ports:
//   CLK              system clock, rising edge
//   Reset            asynchronous active-high reset
//   adc_sdo          ADC serial data, MSB first
//   float_sw         raw float-switch level
//   adc_cs_n         ADC chip select, active low (registered)
//   adc_sclk         ADC serial clock (registered)
//   Moisture_sensor  averaged moisture reading
//   Water_sensor     debounced tank level
//   sample_valid     one-cycle pulse when Moisture_sensor updates
module sensor_frontend
  import sensor_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int AVG_LOG2   = 2,
  parameter int SAMPLE_GAP = 16,
  parameter int DEBOUNCE   = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  adc_sdo,
  input  logic [WATER_BITS-1:0] float_sw,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic [ADC_BITS-1:0]   Moisture_sensor,
  output logic [WATER_BITS-1:0] Water_sensor,
  output logic                  sample_valid
);

  localparam int PHASE_W = $clog2(2 * CLK_DIV);
  localparam int GAP_W   = $clog2(SAMPLE_GAP);
  localparam int ACC_W   = ADC_BITS + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;

  localparam logic [PHASE_W-1:0] PHASE_RISE = PHASE_W'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(CLK_DIV);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * CLK_DIV - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [CNT_W-1:0]   CONV_TOTAL = CNT_W'(2 ** AVG_LOG2);

  adc_state_t state;
  adc_state_t next_state;

  logic [GAP_W-1:0]    gap_cnt;
  logic [PHASE_W-1:0]  phase_cnt;
  logic [PHASE_W-1:0]  phase_nxt;
  logic [2:0]          bit_cnt;
  logic [ADC_BITS-1:0] shift_reg;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    conv_cnt;
  logic                sclk_nxt;

  // Next-state logic for the ADC sequencer. The phase counter walks one
  // bit period (low half then high half); the last phase of the eighth
  // bit ends the conversion.
  always_comb begin
    next_state = state;
    phase_nxt  = '0;
    case (state)
      IDLE: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = CONV;
        end
      end
      CONV: begin
        phase_nxt = (phase_cnt == PHASE_LAST) ? '0 : phase_cnt + 1'b1;
        if ((phase_cnt == PHASE_LAST) && (bit_cnt == 3'd7)) begin
          next_state = ACC;
        end
      end
      ACC: begin
        next_state = ((conv_cnt + 1'b1) == CONV_TOTAL) ? PUBLISH : IDLE;
      end
      PUBLISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // adc_sclk is derived from the upcoming state and phase so that it can
  // be registered and still line up exactly with adc_cs_n.
  assign sclk_nxt = (next_state == CONV) && (phase_nxt >= PHASE_HIGH);

  // Sequencer state register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ADC datapath: gap and bit timing, serial capture, accumulation and
  // publishing. adc_sdo is sampled on the same edge that raises adc_sclk,
  // while the ADC is guaranteed to hold it steady.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      adc_cs_n        <= 1'b1;
      adc_sclk        <= 1'b0;
      gap_cnt         <= '0;
      phase_cnt       <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      acc             <= '0;
      conv_cnt        <= '0;
      Moisture_sensor <= '0;
      sample_valid    <= 1'b0;
    end else begin
      adc_cs_n     <= (next_state != CONV);
      adc_sclk     <= sclk_nxt;
      phase_cnt    <= phase_nxt;
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
        end
        CONV: begin
          if (phase_cnt == PHASE_RISE) begin
            shift_reg <= {shift_reg[ADC_BITS-2:0], adc_sdo};
          end
          if (phase_cnt == PHASE_LAST) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ACC: begin
          acc      <= acc + ACC_W'(shift_reg);
          conv_cnt <= conv_cnt + 1'b1;
        end
        PUBLISH: begin
          Moisture_sensor <= acc[AVG_LOG2 +: ADC_BITS];
          sample_valid    <= 1'b1;
          acc             <= '0;
          conv_cnt        <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  level_debounce #(
    .WIDTH   (WATER_BITS),
    .DEBOUNCE(DEBOUNCE)
  ) u_water_debounce (
    .clk  (CLK),
    .rst  (Reset),
    .raw  (float_sw),
    .level(Water_sensor)
  );

endmodule

// File: tb/tb_sensor_frontend.sv
// tb_sensor_frontend
// Directed plus randomized bench for sensor_frontend. A serial ADC model
// serves conversion words, a reference model predicts the published
// moisture average, the sample_valid cadence and the debounced water
// level, and every cycle of the run is compared against it.
module tb_sensor_frontend;

  localparam int CLK_DIV    = 4;
  localparam int AVG_LOG2   = 2;
  localparam int SAMPLE_GAP = 16;
  localparam int DEBOUNCE   = 8;
  localparam int AVG_N      = 1 << AVG_LOG2;
  localparam int ROUND      = SAMPLE_GAP + 16 * CLK_DIV + 1;
  localparam int PUB_PERIOD = AVG_N * ROUND + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       adc_sdo = 1'b0;
  logic [1:0] float_sw;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [7:0] moisture;
  logic [1:0] water;
  logic       sample_valid;

  int checks = 0;
  int errors = 0;

  sensor_frontend #(
    .CLK_DIV   (CLK_DIV),
    .AVG_LOG2  (AVG_LOG2),
    .SAMPLE_GAP(SAMPLE_GAP),
    .DEBOUNCE  (DEBOUNCE)
  ) dut (
    .CLK            (clk),
    .Reset          (reset),
    .adc_sdo        (adc_sdo),
    .float_sw       (float_sw),
    .adc_cs_n       (adc_cs_n),
    .adc_sclk       (adc_sclk),
    .Moisture_sensor(moisture),
    .Water_sensor   (water),
    .sample_valid   (sample_valid)
  );

  always #5 clk = ~clk;

  // Serial ADC model: a conversion starts when chip select falls, takes the
  // next queued word (0x20 when the queue is empty) and presents it MSB
  // first, changing data only while adc_sclk is low. It also measures the
  // chip-select low time and the adc_sclk period.
  logic [7:0] adc_queue[$];
  logic [7:0] conv_words[0:1023];
  int         conv_count = 0;
  logic [7:0] cur_word = '0;
  logic       in_conv = 1'b0;
  logic       prev_sclk = 1'b0;
  int         sclk_rises = 0;
  int         cs_low_len = 0;
  int         last_conv_len = 0;
  int         cyc = 0;
  int         last_rise_cyc = 0;
  int         last_sclk_period = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      conv_count = 0;
      in_conv    = 1'b0;
      prev_sclk  = 1'b0;
      sclk_rises = 0;
      cs_low_len = 0;
    end else if (adc_cs_n) begin
      if (in_conv) last_conv_len = cs_low_len;
      in_conv = 1'b0;
    end else begin
      if (!in_conv) begin
        in_conv    = 1'b1;
        cs_low_len = 0;
        sclk_rises = 0;
        prev_sclk  = 1'b0;
        if (adc_queue.size() > 0) cur_word = adc_queue.pop_front();
        else cur_word = 8'h20;
        if (conv_count < 1024) conv_words[conv_count] = cur_word;
        conv_count++;
      end
      cs_low_len++;
      if (adc_sclk && !prev_sclk) begin
        if (sclk_rises > 0) last_sclk_period = cyc - last_rise_cyc;
        last_rise_cyc = cyc;
        sclk_rises++;
      end
      prev_sclk = adc_sclk;
      if (!adc_sclk && sclk_rises < 8) adc_sdo = cur_word[7-sclk_rises];
    end
  end

  // Reference model. Readings are published every PUB_PERIOD edges as the
  // truncated mean of the next AVG_N conversion words. The water level
  // follows float_sw two edges late and adopts a value once it has been
  // seen unchanged for DEBOUNCE consecutive edges.
  int         edge_cnt = 0;
  logic [7:0] exp_moist = '0;
  logic       exp_valid = 1'b0;
  logic [1:0] exp_water = '0;
  logic [1:0] raw_pipe[$];
  logic [1:0] run_val = '0;
  int         run_len = 0;
  logic [1:0] seen;
  int         sum;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt  = 0;
      exp_moist = '0;
      exp_valid = 1'b0;
      exp_water = '0;
      raw_pipe  = '{2'b00, 2'b00};
      run_val   = '0;
      run_len   = 0;
    end else begin
      edge_cnt++;
      exp_valid = ((edge_cnt % PUB_PERIOD) == 0);
      if (exp_valid) begin
        sum = 0;
        for (int i = 0; i < AVG_N; i++)
          sum += int'(conv_words[(edge_cnt / PUB_PERIOD - 1) * AVG_N + i]);
        exp_moist = 8'(sum / AVG_N);
      end
      raw_pipe.push_back(float_sw);
      seen = raw_pipe.pop_front();
      if (seen == run_val) begin
        run_len++;
      end else begin
        run_val = seen;
        run_len = 1;
      end
      if (run_len >= DEBOUNCE) exp_water = run_val;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: run did not reach its end");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] sw);
    float_sw = sw;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_output("sample_valid", 16'(sample_valid), 16'(exp_valid));
      check_output("moisture", 16'(moisture), 16'(exp_moist));
      check_output("water", 16'(water), 16'(exp_water));
    end
  endtask

  task automatic run_to(input int target);
    run_cycles(target - edge_cnt);
  endtask

  logic [7:0] rand_words[8];
  int         rand_sum;
  int         hold;
  bit         found;

  initial begin
    reset = 1'b1;
    apply_stimulus(2'b10);
    repeat (3) @(negedge clk);
    check_output("reset_cs_n", 16'(adc_cs_n), 16'h1);
    check_output("reset_sclk", 16'(adc_sclk), 16'h0);
    check_output("reset_moisture", 16'(moisture), 16'h0);
    check_output("reset_water", 16'(water), 16'h0);
    check_output("reset_valid", 16'(sample_valid), 16'h0);
    reset = 1'b0;

    $display("[TB] constant 0x20 conversions, float_sw 10");
    run_to(9);
    check_output("water_edge9", 16'(water), 16'h0);
    run_to(10);
    check_output("water_edge10", 16'(water), 16'h2);
    run_to(15);
    check_output("cs_edge15", 16'(adc_cs_n), 16'h1);
    run_to(16);
    check_output("cs_edge16", 16'(adc_cs_n), 16'h0);
    run_to(324);
    check_output("valid_edge324", 16'(sample_valid), 16'h0);
    run_to(325);
    check_output("valid_edge325", 16'(sample_valid), 16'h1);
    check_output("moisture_32", 16'(moisture), 16'd32);

    $display("[TB] truncating average with simultaneous water update");
    adc_queue.push_back(8'h10);
    adc_queue.push_back(8'h20);
    adc_queue.push_back(8'h30);
    adc_queue.push_back(8'h41);
    run_to(640);
    apply_stimulus(2'b01);
    run_to(649);
    check_output("water_edge649", 16'(water), 16'h2);
    check_output("valid_edge649", 16'(sample_valid), 16'h0);
    run_to(650);
    check_output("water_edge650", 16'(water), 16'h1);
    check_output("valid_edge650", 16'(sample_valid), 16'h1);
    check_output("moisture_40", 16'(moisture), 16'd40);

    $display("[TB] full-scale conversions and water glitch");
    repeat (4) adc_queue.push_back(8'hFF);
    run_to(660);
    apply_stimulus(2'b11);
    run_cycles(5);
    apply_stimulus(2'b01);
    run_cycles(20);
    check_output("glitch_ignored", 16'(water), 16'h1);
    run_to(690);
    apply_stimulus(2'b11);
    run_to(699);
    check_output("water_hold_edge699", 16'(water), 16'h1);
    run_to(700);
    check_output("water_hold_edge700", 16'(water), 16'h3);
    run_to(975);
    check_output("moisture_ff", 16'(moisture), 16'hFF);
    check_output("valid_edge975", 16'(sample_valid), 16'h1);
    check_output("cs_low_len", 16'(last_conv_len), 16'd64);
    check_output("sclk_period", 16'(last_sclk_period), 16'd8);

    $display("[TB] random conversions and float_sw activity");
    rand_sum = 0;
    for (int i = 0; i < 8; i++) begin
      rand_words[i] = 8'($urandom_range(0, 255));
      adc_queue.push_back(rand_words[i]);
      if (i < 4) rand_sum += int'(rand_words[i]);
    end
    while (edge_cnt < 1290) begin
      apply_stimulus(2'($urandom_range(0, 3)));
      hold = $urandom_range(1, 14);
      if (edge_cnt + hold > 1290) hold = 1290 - edge_cnt;
      run_cycles(hold);
    end
    run_to(1300);
    check_output("moisture_rand1", 16'(moisture), 16'(rand_sum / 4));
    rand_sum = 0;
    for (int i = 4; i < 8; i++) rand_sum += int'(rand_words[i]);
    while (edge_cnt < 1615) begin
      apply_stimulus(2'($urandom_range(0, 3)));
      hold = $urandom_range(1, 14);
      if (edge_cnt + hold > 1615) hold = 1615 - edge_cnt;
      run_cycles(hold);
    end
    run_to(1625);
    check_output("moisture_rand2", 16'(moisture), 16'(rand_sum / 4));

    $display("[TB] reset during conversion bit 4");
    apply_stimulus(2'b11);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (adc_sclk && sclk_rises == 4) found = 1'b1;
    end
    check_output("reach_bit4", 16'(found), 16'h1);
    #2;
    reset = 1'b1;
    #1;
    check_output("midreset_cs_n", 16'(adc_cs_n), 16'h1);
    check_output("midreset_sclk", 16'(adc_sclk), 16'h0);
    check_output("midreset_moisture", 16'(moisture), 16'h0);
    check_output("midreset_water", 16'(water), 16'h0);
    check_output("midreset_valid", 16'(sample_valid), 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_to(10);
    check_output("water_after_reset", 16'(water), 16'h3);
    run_to(15);
    check_output("cs_restart_edge15", 16'(adc_cs_n), 16'h1);
    run_to(16);
    check_output("cs_restart_edge16", 16'(adc_cs_n), 16'h0);
    run_to(324);
    check_output("valid_restart_324", 16'(sample_valid), 16'h0);
    run_to(325);
    check_output("valid_restart_325", 16'(sample_valid), 16'h1);
    check_output("moisture_restart", 16'(moisture), 16'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
